maxpool_stage: RTL and testbench

Streaming 2x2 / stride-2 max-pooling stage that sits directly upstream of the fully-connected top. It consumes the convolution output as one 12-channel pixel vector per valid beat in raster order. It emits pooled 12-channel vectors on the pool_data / pool_valid / pool_end triple that the FC buffer ingests. One line buffer holds half a row of horizontal maxima, so no frame-sized storage is needed.

---
 rtl/pe_pool_pkg.sv | 28 ++
 rtl/pool_line_buf.sv | 32 +++
 rtl/maxpool_stage.sv | 110 +++++++++++
 tb/tb_maxpool_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pool_pkg.sv
// pe_pool_pkg: shared constants, derived widths and the lane-wise max helper
// used by the 2x2 / stride-2 max-pooling stage and its line buffer.
package pe_pool_pkg;

  localparam int CH    = 12;            // channels per pixel vector
  localparam int DW    = 8;             // bits per channel (unsigned)
  localparam int IMG_W = 24;            // conv output width (even)
  localparam int IMG_H = 24;            // conv output height (even)

  localparam int VW    = CH * DW;       // packed vector width
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;     // one entry per horizontal pair
  localparam int LB_AW = COL_W - 1;     // col>>1 addresses the line buffer

  // Lane-wise unsigned max; lane k occupies bits [k*DW +: DW].
  function automatic logic [VW-1:0] vec_max(input logic [VW-1:0] a,
                                            input logic [VW-1:0] b);
    logic [VW-1:0] m;
    m = '0;
    for (int k = 0; k < CH; k++) begin
      m[k*DW +: DW] = (a[k*DW +: DW] >= b[k*DW +: DW]) ? a[k*DW +: DW]
                                                       : b[k*DW +: DW];
    end
    return m;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-row store of horizontal maxima for the pooling stage.
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable (registered write)
//   i_waddr  write address (pair index, col>>1)
//   i_wdata  horizontal-max vector to store
//   i_raddr  read address (pair index, col>>1)
//   o_rdata  asynchronous read data
// Contents are not reset: every entry is written in an even row before the
// following odd row reads it.
module pool_line_buf
  import pe_pool_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [LB_AW-1:0] i_waddr,
  input  logic [VW-1:0]    i_wdata,
  input  logic [LB_AW-1:0] i_raddr,
  output logic [VW-1:0]    o_rdata
);

  logic [VW-1:0] r_mem [LB_D];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxpool_stage.sv
// maxpool_stage: streaming 2x2 / stride-2 max pooling over raster-ordered
// CH-lane pixel vectors.
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_conv_data   input pixel vector, lane k = bits [k*DW +: DW]
//   i_conv_valid  input beat qualifier
//   o_pool_data   pooled vector (holds between strobes)
//   o_pool_valid  one-cycle strobe per pooled vector
//   o_pool_end    strobe coinciding with the last pooled vector of a frame
//   o_busy        high while a frame is partially received
//
// Handshake: a beat transfers on every rising edge where i_conv_valid is high
// and i_rst is low. There is no ready; the stage always accepts and the
// downstream always accepts o_pool_valid. Idle cycles freeze all state.
module maxpool_stage
  import pe_pool_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [VW-1:0] i_conv_data,
  input  logic          i_conv_valid,
  output logic [VW-1:0] o_pool_data,
  output logic          o_pool_valid,
  output logic          o_pool_end,
  output logic          o_busy
);

  if (((IMG_W % 2) != 0) || ((IMG_H % 2) != 0)) begin : g_bad_dims
    $error("maxpool_stage: IMG_W and IMG_H must both be even");
  end

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [VW-1:0]    r_hold;
  logic [VW-1:0]    r_pool_data;
  logic             r_pool_valid;
  logic             r_pool_end;
  logic             r_busy;

  logic             w_last_col;
  logic             w_last_row;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [VW-1:0]    w_h;
  logic [VW-1:0]    w_lb_rdata;
  logic             w_lb_we;
  logic [LB_AW-1:0] w_lb_addr;

  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
  assign w_h        = vec_max(r_hold, i_conv_data);
  assign w_lb_addr  = r_col[COL_W-1:1];
  // Reset wins over a colliding beat, so the write is suppressed as well.
  assign w_lb_we    = i_conv_valid & ~i_rst & r_col[0] & ~r_row[0];

  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (i_conv_valid) begin
      w_col_nxt = w_last_col ? '0 : r_col + 1'b1;
      if (w_last_col) begin
        w_row_nxt = w_last_row ? '0 : r_row + 1'b1;
      end
    end
  end

  pool_line_buf u_line_buf (
    .i_clk   (i_clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_h),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_pool_data  <= '0;
      r_pool_valid <= 1'b0;
      r_pool_end   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pool_valid <= 1'b0;
      r_pool_end   <= 1'b0;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      // o_busy reflects the counters as they stand after this edge.
      r_busy       <= (w_col_nxt != '0) || (w_row_nxt != '0);
      if (i_conv_valid) begin
        if (!r_col[0]) begin
          r_hold <= i_conv_data;
        end else if (r_row[0]) begin
          r_pool_data  <= vec_max(w_lb_rdata, w_h);
          r_pool_valid <= 1'b1;
          r_pool_end   <= w_last_row & w_last_col;
        end
      end
    end
  end

  assign o_pool_data  = r_pool_data;
  assign o_pool_valid = r_pool_valid;
  assign o_pool_end   = r_pool_end;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_maxpool_stage.sv
// tb_maxpool_stage: self-checking bench for maxpool_stage. Frames are built
// in frame_mem; the driver pushes the lane-wise max of each 2x2 window (plus
// the end flag and due cycle) when the closing (odd,odd) beat is driven, and
// a negedge monitor pops and compares every strobe.
module tb_maxpool_stage;
  import pe_pool_pkg::*;

  logic          i_clk;
  logic          i_rst;
  logic [VW-1:0] i_conv_data;
  logic          i_conv_valid;
  logic [VW-1:0] o_pool_data;
  logic          o_pool_valid;
  logic          o_pool_end;
  logic          o_busy;

  maxpool_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_conv_data  (i_conv_data),
    .i_conv_valid (i_conv_valid),
    .o_pool_data  (o_pool_data),
    .o_pool_valid (o_pool_valid),
    .o_pool_end   (o_pool_end),
    .o_busy       (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [VW:0]   exp_q[$];     // {end, data}
  int            due_q[$];     // cycle on which the strobe must be seen
  logic [VW-1:0] obs_q[$];     // observed pooled data, in order
  logic [VW-1:0] ramp_ref[$];  // reference output of a clean ramp frame
  int            end_cnt;
  int            checks   = 0;
  int            failures = 0;

  logic [VW-1:0] frame_mem [IMG_H][IMG_W];

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (o_pool_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d data=%h end=%b", cyc, o_pool_data, o_pool_end);
      end else begin
        logic [VW:0] e;
        int          d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if ({o_pool_end, o_pool_data} !== e || cyc != d) begin
          failures++;
          $display("FAIL strobe got end=%b data=%h cyc=%0d expected end=%b data=%h cyc=%0d",
                   o_pool_end, o_pool_data, cyc, e[VW], e[VW-1:0], d);
        end
      end
      obs_q.push_back(o_pool_data);
      if (o_pool_end === 1'b1) end_cnt++;
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_strobe cyc=%0d expected data=%h due=%0d", cyc, exp_q[0][VW-1:0], due_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [VW-1:0] window_max(input int r, input int c);
    logic [VW-1:0] m;
    logic [DW-1:0] v;
    m = '0;
    for (int k = 0; k < CH; k++) begin
      v = 0;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (frame_mem[r-dr][c-dc][k*DW +: DW] > v) v = frame_mem[r-dr][c-dc][k*DW +: DW];
      m[k*DW +: DW] = v;
    end
    return m;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        for (int k = 0; k < CH; k++)
          frame_mem[r][c][k*DW +: DW] = DW'((r*IMG_W + c + k) % 256);
  endtask

  // Drives the first n_pix pixels of frame_mem; leaves the last beat on the
  // bus so a following call continues without a gap.
  task automatic send_frame(input int n_pix, input int max_gap);
    int gap;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r*IMG_W + c >= n_pix) return;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
          @(posedge i_clk); #1;
          i_conv_valid = 1'b0;
          i_conv_data  = VW'($urandom);
        end
        @(posedge i_clk); #1;
        i_conv_data  = frame_mem[r][c];
        i_conv_valid = 1'b1;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          exp_q.push_back({(r == IMG_H-1 && c == IMG_W-1), window_max(r, c)});
          due_q.push_back(cyc + 1);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      i_conv_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    i_conv_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    end_cnt = 0;
  endtask

  task automatic check_drained(input string name);
    idle(4);
    checks++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d busy=%b expected pending=0 busy=0", name, exp_q.size(), o_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    i_conv_valid = 1'b0;
    i_conv_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if ({o_pool_valid, o_pool_end, o_busy} !== 3'b000 || o_pool_data !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%b end=%b busy=%b data=%h expected all 0",
               o_pool_valid, o_pool_end, o_busy, o_pool_data);
    end
  endtask

  task automatic test_ramp();
    fill_ramp();
    clear_obs();
    send_frame(1, 0);
    idle(1);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_first got=%b expected=1", o_busy);
    end
    // finish the frame from pixel 1 onward
    for (int p = 1; p < IMG_W*IMG_H; p++) begin
      @(posedge i_clk); #1;
      i_conv_data  = frame_mem[p / IMG_W][p % IMG_W];
      i_conv_valid = 1'b1;
      if (((p / IMG_W) % 2 == 1) && ((p % IMG_W) % 2 == 1)) begin
        exp_q.push_back({(p == IMG_W*IMG_H-1), window_max(p / IMG_W, p % IMG_W)});
        due_q.push_back(cyc + 1);
      end
    end
    check_drained("ramp");
    checks++;
    if (obs_q.size() != 144 || end_cnt != 1) begin
      failures++;
      $display("FAIL ramp_count got=%0d ends=%0d expected=144 ends=1", obs_q.size(), end_cnt);
    end
    if (obs_q.size() == 144) begin
      checks++;
      if (obs_q[0][7:0] !== 8'd25 || obs_q[143][7:0] !== 8'd63) begin
        failures++;
        $display("FAIL ramp_corners got first=%0d last=%0d expected first=25 last=63",
                 obs_q[0][7:0], obs_q[143][7:0]);
      end
    end
    ramp_ref = obs_q;
  endtask

  task automatic test_max_position();
    int            lane;
    logic [VW-1:0] bg;
    // 0xFF in one lane at each of the four window positions, zero elsewhere;
    // then 0x80 against a 0x7F background.
    for (int pass = 0; pass < 2; pass++) begin
      bg = '0;
      for (int k = 0; k < CH; k++) bg[k*DW +: DW] = (pass == 0) ? 8'h00 : 8'h7F;
      for (int r = 0; r < IMG_H; r++)
        for (int c = 0; c < IMG_W; c++)
          frame_mem[r][c] = bg;
      for (int pr = 0; pr < IMG_H/2; pr++) begin
        for (int pc = 0; pc < IMG_W/2; pc++) begin
          int pos;
          pos  = (pr + pc) % 4;
          lane = (pr * 5 + pc) % CH;
          frame_mem[2*pr + pos/2][2*pc + pos%2][lane*DW +: DW] = (pass == 0) ? 8'hFF : 8'h80;
        end
      end
      clear_obs();
      send_frame(IMG_W*IMG_H, 0);
      check_drained("maxpos");
      checks++;
      if (obs_q.size() != 144) begin
        failures++;
        $display("FAIL maxpos_count pass=%0d got=%0d expected=144", pass, obs_q.size());
      end else begin
        // window (0,pc) for pc=0..3 exercises positions 0..3, lane pc
        for (int pc = 0; pc < 4; pc++) begin
          logic [VW-1:0] want;
          want = bg;
          want[pc*DW +: DW] = (pass == 0) ? 8'hFF : 8'h80;
          checks++;
          if (obs_q[pc] !== want) begin
            failures++;
            $display("FAIL maxpos pass=%0d pos=%0d got=%h expected=%h", pass, pc, obs_q[pc], want);
          end
        end
      end
    end
  endtask

  task automatic test_bubbles();
    int bad;
    fill_ramp();
    clear_obs();
    send_frame(IMG_W*IMG_H, 5);
    check_drained("bubbles");
    bad = 0;
    if (obs_q.size() != ramp_ref.size()) bad = 1;
    else for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== ramp_ref[i]) bad++;
    checks++;
    if (bad != 0 || end_cnt != 1) begin
      failures++;
      $display("FAIL bubbles_vs_ramp got n=%0d diffs=%0d ends=%0d expected n=%0d diffs=0 ends=1",
               obs_q.size(), bad, end_cnt, ramp_ref.size());
    end
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    clear_obs();
    send_frame(IMG_W*IMG_H, 0);
    send_frame(IMG_W*IMG_H, 0);
    check_drained("b2b");
    checks++;
    if (obs_q.size() != 288 || end_cnt != 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d ends=%0d expected=288 ends=2", obs_q.size(), end_cnt);
    end else begin
      checks++;
      if (obs_q[144] !== obs_q[0] || obs_q[0] !== ramp_ref[0]) begin
        failures++;
        $display("FAIL b2b_first got f1=%h f2=%h expected both=%h", obs_q[0], obs_q[144], ramp_ref[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    fill_ramp();
    clear_obs();
    send_frame(100, 0);
    idle(1);
    checks++;
    if (o_busy !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_pre busy=%b pending=%0d expected busy=1 pending=0", o_busy, exp_q.size());
    end
    pulse_reset();
    checks++;
    if (o_busy !== 1'b0 || o_pool_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_post busy=%b valid=%b expected 0 0", o_busy, o_pool_valid);
    end
    clear_obs();
    send_frame(IMG_W*IMG_H, 0);
    check_drained("midreset");
    checks++;
    if (obs_q.size() != 144 || end_cnt != 1) begin
      failures++;
      $display("FAIL midreset_count got=%0d ends=%0d expected=144 ends=1", obs_q.size(), end_cnt);
    end
  endtask

  task automatic test_reset_collision();
    int bad;
    fill_ramp();
    clear_obs();
    @(posedge i_clk); #1;
    i_rst        = 1'b1;
    i_conv_valid = 1'b1;
    i_conv_data  = '1;
    @(posedge i_clk); #1;
    i_rst        = 1'b0;
    i_conv_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL collision_busy got=%b expected=0", o_busy);
    end
    send_frame(IMG_W*IMG_H, 0);
    check_drained("collision");
    bad = 0;
    if (obs_q.size() != ramp_ref.size()) bad = 1;
    else for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== ramp_ref[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL collision_vs_ramp got n=%0d diffs=%0d expected n=%0d diffs=0",
               obs_q.size(), bad, ramp_ref.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_ramp();
    test_max_position();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    test_reset_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
